// File: rtl/l1_train_pkg.sv
// l1_train_pkg
//   Shared definitions for the L1 training sequencer: FSM state encoding,
//   update-command op codes, layer dimensions and the first-spike picker.
package l1_train_pkg;

  localparam int N_NEURONS = 2;
  localparam int N_INPUTS  = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    OBSERVE  = 3'd1,
    ISSUE    = 3'd2,
    WAIT_L2  = 3'd3,
    COOLDOWN = 3'd4
  } state_t;

  localparam logic [1:0] OP_NONE   = 2'b00;
  localparam logic [1:0] OP_REWARD = 2'b01;
  localparam logic [1:0] OP_PUNISH = 2'b10;

  // One-hot of the lowest-index spiking neuron; neuron 1 (bit 0) wins ties.
  function automatic logic [N_NEURONS-1:0] first_spike(input logic [N_NEURONS-1:0] spikes);
    first_spike = '0;
    for (int i = N_NEURONS - 1; i >= 0; i--) begin
      if (spikes[i]) begin
        first_spike    = '0;
        first_spike[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/l1_epoch_counter.sv
// l1_epoch_counter
//   Saturating count of completed training windows plus a sticky flag that
//   rises the cycle after the count reaches P_EPOCHS.
//   Ports:
//     i_clk, i_rst  clock, asynchronous active-high reset
//     i_inc         one-cycle pulse: a window has completed
//     o_epochs      completed windows, saturates at P_EPOCHS
//     o_end         sticky end-of-training flag
module l1_epoch_counter
  import l1_train_pkg::*;
#(
  parameter int P_EPOCHS = 20120,
  parameter int EP_W     = $clog2(P_EPOCHS + 1)
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inc,
  output logic [EP_W-1:0] o_epochs,
  output logic            o_end
);

  localparam logic [EP_W-1:0] EP_MAX = EP_W'(P_EPOCHS);

  logic at_max;

  assign at_max = (o_epochs == EP_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_epochs <= '0;
      o_end    <= 1'b0;
    end else begin
      if (i_inc && !at_max) begin
        o_epochs <= o_epochs + 1'b1;
      end
      if (at_max) begin
        o_end <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/l1_train_sequencer.sv
// l1_train_sequencer
//   Sequences one training window of the 2-neuron, 8-input L1 layer:
//   accepts an input event, observes spikes and GAS, issues at most one
//   reward/punish command over valid/ready, waits out the LAS window,
//   then counts the epoch.
//   Ports:
//     i_clk, i_rst        clock, asynchronous active-high reset
//     i_event             input channel events (any bit = event)
//     i_l1_spikeout       L1 neuron spike levels
//     i_gas, i_las        global / local attention
//     o_upd_valid/i_upd_ready, o_upd_op, o_upd_sel   update command
//     o_ts_capture        per-neuron time-surface capture pulse
//     o_las, o_las_seen   winner captured / LAS seen this window
//     o_busy, o_window_done, o_overrun               status
//     o_epochs, o_endof_epochs                       epoch progress
module l1_train_sequencer
  import l1_train_pkg::*;
#(
  parameter int P_PASS_L1   = 7,
  parameter int P_PASS_L2   = 9,
  parameter int P_WAIT_CLKS = 10,
  parameter int P_EPOCHS    = 20120
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [N_INPUTS-1:0]             i_event,
  input  logic [N_NEURONS-1:0]            i_l1_spikeout,
  input  logic                            i_gas,
  input  logic                            i_las,
  output logic                            o_upd_valid,
  input  logic                            i_upd_ready,
  output logic [1:0]                      o_upd_op,
  output logic [N_NEURONS-1:0]            o_upd_sel,
  output logic [N_NEURONS-1:0]            o_ts_capture,
  output logic                            o_las,
  output logic                            o_las_seen,
  output logic                            o_busy,
  output logic                            o_window_done,
  output logic                            o_overrun,
  output logic [$clog2(P_EPOCHS+1)-1:0]   o_epochs,
  output logic                            o_endof_epochs
);

  if (!(P_PASS_L1 >= 1 && P_PASS_L1 < P_PASS_L2 && P_PASS_L2 <= P_WAIT_CLKS)) begin : g_param_check
    $error("l1_train_sequencer: need 1 <= P_PASS_L1 < P_PASS_L2 <= P_WAIT_CLKS");
  end

  localparam int K_W = $clog2(P_WAIT_CLKS + 1);
  localparam logic [K_W-1:0] K_ONE  = K_W'(1);
  localparam logic [K_W-1:0] K_L1   = K_W'(P_PASS_L1);
  localparam logic [K_W-1:0] K_L2   = K_W'(P_PASS_L2);
  localparam logic [K_W-1:0] K_WAIT = K_W'(P_WAIT_CLKS);

  state_t               state_q, state_d;
  logic [K_W-1:0]       k_q, k_d;
  logic [N_NEURONS-1:0] winner_q, winner_now, capture;
  logic                 gas_q, gas_now;
  logic                 las_seen_q, las_now;
  logic                 upd_valid_q;
  logic [1:0]           upd_op_q;
  logic [N_NEURONS-1:0] upd_sel_q;
  logic                 overrun_q;
  logic                 accept, observing, las_window;
  logic                 issue_enter, done;
  logic                 end_of_epochs;

  // Acceptance happens in IDLE itself; reset is folded in so the
  // combinational capture pulse stays low while reset is asserted.
  assign accept    = (state_q == IDLE) && (|i_event) && !end_of_epochs && !i_rst;
  assign observing = accept || (state_q == OBSERVE);

  // Flags from the previous window are ignored in the acceptance cycle so
  // that clearing and first sampling happen together.
  assign capture    = (observing && (accept || (winner_q == '0)))
                      ? first_spike(i_l1_spikeout) : {N_NEURONS{1'b0}};
  assign winner_now = (accept ? {N_NEURONS{1'b0}} : winner_q) | capture;
  assign gas_now    = (accept ? 1'b0 : gas_q) | (observing & i_gas);
  assign las_window = accept || ((state_q != IDLE) && (k_q <= K_L2));
  assign las_now    = (accept ? 1'b0 : las_seen_q) | (las_window & i_las);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    issue_enter = 1'b0;
    done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = OBSERVE;
          k_d     = K_ONE;
        end
      end
      OBSERVE: begin
        k_d = k_q + 1'b1;
        if (k_q == K_L1) begin
          if (gas_now) begin
            state_d     = ISSUE;
            issue_enter = 1'b1;
          end else begin
            state_d = WAIT_L2;
          end
        end
      end
      ISSUE: begin
        // k is frozen here, so a stalled datapath stretches the window.
        if (i_upd_ready) begin
          state_d = WAIT_L2;
        end
      end
      WAIT_L2: begin
        if (k_q >= K_L2) begin
          if (k_q >= K_WAIT) begin
            done    = 1'b1;
            state_d = IDLE;
            k_d     = '0;
          end else begin
            state_d = COOLDOWN;
            k_d     = k_q + 1'b1;
          end
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      COOLDOWN: begin
        if (k_q >= K_WAIT) begin
          done    = 1'b1;
          state_d = IDLE;
          k_d     = '0;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        k_d     = '0;
      end
    endcase
  end

  // ---- state / window counter ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // ---- window flags ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      winner_q   <= '0;
      gas_q      <= 1'b0;
      las_seen_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      winner_q   <= winner_now;
      gas_q      <= gas_now;
      las_seen_q <= las_now;
      if ((state_q != IDLE) && (|i_event)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // ---- update command ----
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      upd_valid_q <= 1'b0;
      upd_op_q    <= OP_NONE;
      upd_sel_q   <= '0;
    end else if (issue_enter) begin
      upd_valid_q <= 1'b1;
      if (|winner_now) begin
        upd_op_q  <= OP_REWARD;
        upd_sel_q <= winner_now;
      end else begin
        upd_op_q  <= OP_PUNISH;
        upd_sel_q <= '0;
      end
    end else if (upd_valid_q && i_upd_ready) begin
      upd_valid_q <= 1'b0;
      upd_op_q    <= OP_NONE;
      upd_sel_q   <= '0;
    end
  end

  l1_epoch_counter #(
    .P_EPOCHS (P_EPOCHS)
  ) u_epoch_counter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_inc    (done),
    .o_epochs (o_epochs),
    .o_end    (end_of_epochs)
  );

  assign o_upd_valid    = upd_valid_q;
  assign o_upd_op       = upd_op_q;
  assign o_upd_sel      = upd_sel_q;
  assign o_ts_capture   = capture;
  assign o_las          = |winner_q;
  assign o_las_seen     = las_seen_q;
  assign o_busy         = (state_q != IDLE);
  assign o_window_done  = done;
  assign o_overrun      = overrun_q;
  assign o_endof_epochs = end_of_epochs;

endmodule

// File: tb/tb_l1_train_sequencer.sv
// tb_l1_train_sequencer
//   Directed bench for l1_train_sequencer (P_EPOCHS=3). Inputs change 1
//   time unit after the rising edge; outputs are sampled 2 units after it.
module tb_l1_train_sequencer;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic [7:0] i_event = '0;
  logic [1:0] i_l1_spikeout = '0;
  logic       i_gas = 1'b0;
  logic       i_las = 1'b0;
  logic       i_upd_ready = 1'b0;
  logic       o_upd_valid;
  logic [1:0] o_upd_op;
  logic [1:0] o_upd_sel;
  logic [1:0] o_ts_capture;
  logic       o_las;
  logic       o_las_seen;
  logic       o_busy;
  logic       o_window_done;
  logic       o_overrun;
  logic [1:0] o_epochs;
  logic       o_endof_epochs;

  int checks   = 0;
  int failures = 0;
  int cap_cnt  = 0;
  int vld_cnt  = 0;
  int xfer_cnt = 0;

  l1_train_sequencer #(
    .P_PASS_L1   (7),
    .P_PASS_L2   (9),
    .P_WAIT_CLKS (10),
    .P_EPOCHS    (3)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_event        (i_event),
    .i_l1_spikeout  (i_l1_spikeout),
    .i_gas          (i_gas),
    .i_las          (i_las),
    .o_upd_valid    (o_upd_valid),
    .i_upd_ready    (i_upd_ready),
    .o_upd_op       (o_upd_op),
    .o_upd_sel      (o_upd_sel),
    .o_ts_capture   (o_ts_capture),
    .o_las          (o_las),
    .o_las_seen     (o_las_seen),
    .o_busy         (o_busy),
    .o_window_done  (o_window_done),
    .o_overrun      (o_overrun),
    .o_epochs       (o_epochs),
    .o_endof_epochs (o_endof_epochs)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, settle, tally.
  task automatic step(input logic [7:0] ev, input logic [1:0] sp,
                      input logic g, input logic l, input logic r);
    @(posedge i_clk);
    #1;
    i_event       = ev;
    i_l1_spikeout = sp;
    i_gas         = g;
    i_las         = l;
    i_upd_ready   = r;
    #1;
    if (o_ts_capture != 2'b00) cap_cnt++;
    if (o_upd_valid) vld_cnt++;
    if (o_upd_valid && i_upd_ready) xfer_cnt++;
  endtask

  initial begin
    // ---------------- reset state ----------------
    @(posedge i_clk);
    @(posedge i_clk);
    #2;
    chk("rst_valid", o_upd_valid, 0);
    chk("rst_op", o_upd_op, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_epochs", o_epochs, 0);
    chk("rst_flags", {o_las, o_las_seen, o_overrun, o_endof_epochs, o_window_done}, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    step(8'h00, 2'b00, 0, 0, 1);

    // ---------------- A: GAS at acceptance, neuron 2 spikes at k=4 ----------------
    cap_cnt = 0; vld_cnt = 0; xfer_cnt = 0;
    step(8'h08, 2'b00, 1, 0, 1);                       // k0 accept
    chk("a_busy_k0", o_busy, 0);
    step(8'h00, 2'b00, 0, 0, 1);                       // k1
    chk("a_busy_k1", o_busy, 1);
    step(8'h00, 2'b00, 0, 0, 1);                       // k2
    step(8'h00, 2'b00, 0, 0, 1);                       // k3
    chk("a_las_k3", o_las, 0);
    step(8'h00, 2'b10, 0, 0, 1);                       // k4
    chk("a_cap_k4", o_ts_capture, 2'b10);
    step(8'h00, 2'b10, 0, 0, 1);                       // k5
    chk("a_cap_k5", o_ts_capture, 2'b00);
    chk("a_las_k5", o_las, 1);
    step(8'h00, 2'b00, 0, 0, 1);                       // k6
    step(8'h00, 2'b00, 0, 0, 1);                       // k7
    chk("a_valid_k7", o_upd_valid, 0);
    step(8'h00, 2'b00, 0, 0, 1);                       // k8 ISSUE
    chk("a_valid_k8", o_upd_valid, 1);
    chk("a_op", o_upd_op, 2'b01);
    chk("a_sel", o_upd_sel, 2'b10);
    step(8'h00, 2'b00, 0, 0, 1);                       // WAIT_L2 k8
    chk("a_valid_drop", o_upd_valid, 0);
    step(8'h00, 2'b00, 0, 1, 1);                       // k9, LAS at window edge
    chk("a_lasseen_k9", o_las_seen, 0);
    chk("a_done_k9", o_window_done, 0);
    step(8'h00, 2'b00, 0, 0, 1);                       // k10
    chk("a_lasseen_k10", o_las_seen, 1);
    chk("a_done_k10", o_window_done, 1);
    chk("a_epochs_k10", o_epochs, 0);

    // ---------------- B: back-to-back, GAS only at k=7, no spike ----------------
    step(8'h01, 2'b00, 0, 0, 1);                       // k0 accept, first IDLE cycle
    chk("a_epochs", o_epochs, 1);
    chk("a_done_clr", o_window_done, 0);
    chk("a_xfers", xfer_cnt, 1);
    chk("a_caps", cap_cnt, 1);
    cap_cnt = 0; vld_cnt = 0; xfer_cnt = 0;
    step(8'h00, 2'b00, 0, 0, 1);                       // k1
    chk("b_busy", o_busy, 1);
    chk("b_las_clr", o_las, 0);
    chk("b_lasseen_clr", o_las_seen, 0);
    for (int i = 2; i <= 6; i++) step(8'h00, 2'b00, 0, 0, 1);
    step(8'h00, 2'b00, 1, 0, 1);                       // k7 GAS
    step(8'h00, 2'b00, 0, 0, 1);                       // k8 ISSUE
    chk("b_valid", o_upd_valid, 1);
    chk("b_op", o_upd_op, 2'b10);
    chk("b_sel", o_upd_sel, 2'b00);
    step(8'h00, 2'b00, 0, 0, 1);                       // WAIT_L2 k8
    step(8'h00, 2'b00, 0, 0, 1);                       // k9
    step(8'h00, 2'b00, 0, 1, 1);                       // k10, LAS too late
    chk("b_done", o_window_done, 1);
    step(8'h00, 2'b00, 0, 0, 1);                       // IDLE
    chk("b_lasseen_late", o_las_seen, 0);
    chk("b_las", o_las, 0);
    chk("b_epochs", o_epochs, 2);
    chk("b_xfers", xfer_cnt, 1);

    // ---------------- C: no GAS, neuron 1 spikes at k=2 ----------------
    cap_cnt = 0; vld_cnt = 0; xfer_cnt = 0;
    step(8'h80, 2'b00, 0, 0, 1);                       // k0 accept
    step(8'h00, 2'b00, 0, 0, 1);                       // k1
    step(8'h00, 2'b01, 0, 0, 1);                       // k2
    chk("c_cap", o_ts_capture, 2'b01);
    for (int i = 3; i <= 7; i++) step(8'h00, 2'b00, 0, 0, 1);
    step(8'h00, 2'b00, 0, 0, 1);                       // WAIT_L2 k8
    chk("c_no_valid_k8", o_upd_valid, 0);
    step(8'h00, 2'b00, 0, 0, 1);                       // k9
    step(8'h00, 2'b00, 0, 0, 1);                       // k10
    chk("c_done", o_window_done, 1);
    step(8'h00, 2'b00, 0, 0, 1);                       // IDLE
    chk("c_epochs", o_epochs, 3);
    chk("c_end_early", o_endof_epochs, 0);
    chk("c_las_held", o_las, 1);
    chk("c_vld_cycles", vld_cnt, 0);
    step(8'h00, 2'b00, 0, 0, 1);
    chk("c_end", o_endof_epochs, 1);
    step(8'hFF, 2'b11, 1, 0, 1);                       // ignored event
    chk("c_ign_cap", o_ts_capture, 2'b00);
    step(8'h00, 2'b00, 0, 0, 1);
    chk("c_ign_busy", o_busy, 0);
    chk("c_ign_overrun", o_overrun, 0);
    chk("c_sat_epochs", o_epochs, 3);

    // ---------------- reset, then D: simultaneous spikes at acceptance ----------------
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    step(8'h00, 2'b00, 0, 0, 1);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    chk("d_rst_epochs", o_epochs, 0);
    chk("d_rst_end", o_endof_epochs, 0);
    cap_cnt = 0; vld_cnt = 0; xfer_cnt = 0;
    step(8'h02, 2'b11, 1, 0, 1);                       // k0 accept
    chk("d_cap_k0", o_ts_capture, 2'b01);
    for (int i = 1; i <= 5; i++) step(8'h00, 2'b00, 0, 0, 1);
    step(8'h00, 2'b10, 0, 0, 1);                       // k6
    chk("d_cap_k6", o_ts_capture, 2'b00);
    step(8'h00, 2'b00, 0, 0, 1);                       // k7
    step(8'h00, 2'b00, 0, 0, 1);                       // k8 ISSUE
    chk("d_valid", o_upd_valid, 1);
    chk("d_op", o_upd_op, 2'b01);
    chk("d_sel", o_upd_sel, 2'b01);
    for (int i = 0; i < 3; i++) step(8'h00, 2'b00, 0, 0, 1);
    chk("d_done", o_window_done, 1);
    chk("d_caps", cap_cnt, 1);
    chk("d_xfers", xfer_cnt, 1);

    // ---------------- E: ready stalled 5 cycles, event while busy ----------------
    step(8'h00, 2'b00, 0, 0, 0);                       // IDLE
    chk("e_epochs_before", o_epochs, 1);
    cap_cnt = 0; vld_cnt = 0; xfer_cnt = 0;
    step(8'h10, 2'b00, 1, 0, 0);                       // k0 accept
    for (int i = 1; i <= 7; i++) step(8'h00, 2'b00, 0, 0, 0);
    for (int i = 0; i <= 5; i++) begin                 // ISSUE, ready on 6th cycle
      step((i == 1) ? 8'h20 : 8'h00, 2'b00, 0, 0, (i == 5));
      chk("e_valid_hold", o_upd_valid, 1);
      chk("e_op_hold", o_upd_op, 2'b10);
      chk("e_sel_hold", o_upd_sel, 2'b00);
      if (i == 1) chk("e_overrun_pre", o_overrun, 0);
      if (i == 2) chk("e_overrun", o_overrun, 1);
    end
    step(8'h00, 2'b00, 0, 0, 1);                       // WAIT_L2 k8
    chk("e_valid_drop", o_upd_valid, 0);
    step(8'h00, 2'b00, 0, 0, 1);                       // k9
    chk("e_done_k9", o_window_done, 0);
    step(8'h00, 2'b00, 0, 0, 1);                       // k10
    chk("e_done", o_window_done, 1);
    chk("e_vld_cycles", vld_cnt, 6);
    chk("e_xfers", xfer_cnt, 1);

    // ---------------- F: reset asserted during ISSUE ----------------
    step(8'h00, 2'b00, 0, 0, 0);                       // IDLE
    chk("f_epochs_before", o_epochs, 2);
    step(8'h04, 2'b10, 1, 1, 0);                       // k0 accept
    for (int i = 1; i <= 7; i++) step(8'h00, 2'b00, 0, 0, 0);
    step(8'h00, 2'b00, 0, 0, 0);                       // k8 ISSUE
    chk("f_valid_pre", o_upd_valid, 1);
    i_rst = 1'b1;
    #1;
    chk("f_rst_valid", o_upd_valid, 0);
    chk("f_rst_op_sel", {o_upd_op, o_upd_sel}, 0);
    chk("f_rst_busy", o_busy, 0);
    chk("f_rst_flags", {o_las, o_las_seen, o_overrun, o_endof_epochs}, 0);
    chk("f_rst_epochs", o_epochs, 0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    vld_cnt = 0; xfer_cnt = 0;
    for (int i = 0; i < 12; i++) step(8'h00, 2'b00, 0, 0, 1);
    chk("f_no_cmd", vld_cnt, 0);
    chk("f_idle", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
